// File: rtl/mem_access_unit.sv
// Data-memory load/store stage: one req/ack transaction per access, 2+ cycles accept-to-done,
// stalls the pipeline via busy while waiting; misaligned/illegal/timed-out accesses end with err.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [1:0]        memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       rd_op;
    logic             lo_half;
    logic [CNT_W-1:0] cnt;

    logic             access;
    logic             illegal;
    logic             misalign;
    logic [15:0]      half;
    logic [31:0]      fmt_data;

    assign access  = valid && (memread != 2'd0 || memwrite);
    assign illegal = (memread != 2'd0) && memwrite;
    // Word accesses need both low bits clear, halfword accesses only bit 0.
    assign misalign = (memwrite || memread == 2'd1) ? (addr[1:0] != 2'b00) : addr[0];

    // Big-endian: the lower byte address holds the upper half of the word.
    assign half = lo_half ? mem_rdata[15:0] : mem_rdata[31:16];

    always_comb begin
        fmt_data = 32'd0;
        case (rd_op)
            2'd1:    fmt_data = mem_rdata;
            2'd2:    fmt_data = {{16{half[15]}}, half};
            2'd3:    fmt_data = {16'd0, half};
            default: fmt_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            rd_op     <= 2'd0;
            lo_half   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        rd_op     <= memread;
                        lo_half   <= addr[1];
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= wdata;
                        if (illegal || misalign) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            rdata <= 32'd0;
                        end else begin
                            state   <= REQ;
                            busy    <= 1'b1;
                            mem_req <= 1'b1;
                            mem_we  <= memwrite;
                            cnt     <= '0;
                        end
                    end
                end
                REQ: begin
                    // An ack in the expiry cycle still counts as success.
                    if (mem_ack) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        rdata   <= fmt_data;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: expected {err, rdata} queued per access, popped on done.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [1:0]  memread = 2'd0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .memread   (memread),
        .memwrite  (memwrite),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_err", {31'd0, err}, {31'd0, e.err});
                check("sb_rdata", rdata, e.rdata);
            end
        end
    end

    // ack_at: REQ cycle (1-based) in which mem_ack is raised, 0 = never.
    task automatic run(input string tag, input logic [1:0] rd, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] md,
                       input logic exp_err, input logic [31:0] exp_rd, input int exp_req);
        int req_cycles;
        int done_at;
        exp_t e;
        e.err   = exp_err;
        e.rdata = exp_rd;
        sb_q.push_back(e);
        @(negedge clk);
        valid = 1'b1; memread = rd; memwrite = we; addr = a; wdata = wd;
        @(negedge clk);
        valid = 1'b0; memread = 2'd0; memwrite = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'd0;
        req_cycles = 0;
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                done_at = c;
                break;
            end
            if (mem_req) begin
                req_cycles++;
                check({tag, "_busy"}, {31'd0, busy}, 32'd1);
                check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
                check({tag, "_mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
                check({tag, "_mem_wdata"}, mem_wdata, wd);
                mem_ack   = (req_cycles == ack_at);
                mem_rdata = md;
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        check({tag, "_done_seen"}, {31'd0, done_at != 0}, 32'd1);
        check({tag, "_req_cycles"}, req_cycles, exp_req);
        check({tag, "_latency"}, done_at, exp_req + 1);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        check({tag, "_rdata_hold"}, rdata, exp_rd);
    endtask

    initial begin
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("lw",       2'd1, 1'b0, 32'h10, 32'h0, 1,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1);
        run("lh_lo",    2'd2, 1'b0, 32'h12, 32'h0, 1,  32'h12348001, 1'b0, 32'hFFFF8001, 1);
        run("lhu_lo",   2'd3, 1'b0, 32'h12, 32'h0, 1,  32'h12348001, 1'b0, 32'h00008001, 1);
        run("lh_hi",    2'd2, 1'b0, 32'h10, 32'h0, 1,  32'h12348001, 1'b0, 32'h00001234, 1);
        run("lh_hi_neg",2'd2, 1'b0, 32'h18, 32'h0, 2,  32'h80007FFF, 1'b0, 32'hFFFF8000, 2);
        run("lhu_hi",   2'd3, 1'b0, 32'h1C, 32'h0, 1,  32'hBEEF0001, 1'b0, 32'h0000BEEF, 1);
        run("sw",       2'd0, 1'b1, 32'h20, 32'hCAFEF00D, 4, 32'h11111111, 1'b0, 32'h0, 4);
        run("lw_mis",   2'd1, 1'b0, 32'h22, 32'h0, 1,  32'h0, 1'b1, 32'h0, 0);
        run("lh_mis",   2'd2, 1'b0, 32'h13, 32'h0, 1,  32'h0, 1'b1, 32'h0, 0);
        run("sw_mis",   2'd0, 1'b1, 32'h21, 32'h77, 1, 32'h0, 1'b1, 32'h0, 0);
        run("illegal",  2'd1, 1'b1, 32'h10, 32'h0, 1,  32'h0, 1'b1, 32'h0, 0);
        run("timeout",  2'd1, 1'b0, 32'h30, 32'h0, 0,  32'h0, 1'b1, 32'h0, 16);
        run("ack_last", 2'd1, 1'b0, 32'h34, 32'h0, 16, 32'hA5A5C3C3, 1'b0, 32'hA5A5C3C3, 16);

        // Reset in the middle of REQ must drop outputs without a clock edge and yield no done.
        @(negedge clk);
        valid = 1'b1; memread = 2'd1; memwrite = 1'b0; addr = 32'h40;
        @(negedge clk);
        valid = 1'b0; memread = 2'd0;
        check("mid_req_up", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("lw_after_rst", 2'd1, 1'b0, 32'h44, 32'h0, 2, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 2);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
